// File: rtl/ssram_responder.sv
// ssram_responder: device-side model of one pipelined synchronous SRAM chip.
// It latches an address on ADSP/ADSC, writes byte lanes, and returns read data
// from a registered output two edges after the address is latched.
//
// Optional build macro: SSRAM_RESPONDER_FLOWTHROUGH_EN selects a flow-through
// output, where data_out is driven combinationally from the array.
//
// Ports:
//   clk_i       bus clock
//   rst_i       asynchronous active-high reset
//   address_in  word address; bits above ADDR_WIDTH-1 are ignored (aliasing)
//   adsp_n      processor address strobe (has priority over adsc_n)
//   adsc_n      controller address strobe
//   adv_n       burst advance (linear wrap on address[1:0])
//   gw_n        global write, writes all four bytes
//   we_n        byte write enable, qualified by be_n
//   be_n        byte lane enables, bit i covers data[8i+7:8i]
//   oe_n        output enable, asynchronous gate on data_oe
//   ce_n        chip enable, sampled with the strobes
//   data_in     write data
//   data_out    read data
//   data_oe     high while this chip drives data_out onto the shared bus
module ssram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [26:0] address_in,
  input  logic        adsp_n,
  input  logic        adsc_n,
  input  logic        adv_n,
  input  logic        gw_n,
  input  logic        we_n,
  input  logic [3:0]  be_n,
  input  logic        oe_n,
  input  logic        ce_n,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_oe
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic                  selected_q, selected_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rvalid_q, rvalid_d;
  logic [3:0]            wr_be_c;
  logic                  no_write_c;

  // Upper address bits alias onto the implemented array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_in[26:ADDR_WIDTH];

  // Address latch and burst advance. Both strobes act identically on ce_n,
  // so taking either one as "strobe present" preserves ADSP priority.
  always_comb begin
    selected_d = selected_q;
    addr_d     = addr_q;
    if (!adsp_n || !adsc_n) begin
      if (!ce_n) begin
        addr_d     = address_in[ADDR_WIDTH-1:0];
        selected_d = 1'b1;
      end else begin
        selected_d = 1'b0;
      end
    end else if (!adv_n && selected_q) begin
      addr_d[1:0] = addr_q[1:0] + 2'd1;
    end
  end

  // Byte lanes written at this edge; global write overrides be_n.
  always_comb begin
    wr_be_c = 4'h0;
    if (!gw_n) begin
      wr_be_c = 4'hF;
    end else if (!we_n) begin
      wr_be_c = ~be_n;
    end
  end

  assign no_write_c = we_n & gw_n;

`ifdef SSRAM_RESPONDER_FLOWTHROUGH_EN
  // Flow-through: valid from the cycle after latch while no write is pending.
  assign rvalid_d = selected_d & no_write_c;
  assign data_out = mem[addr_q];
`else
  logic [31:0] data_out_q;

  assign rvalid_d = selected_q & no_write_c;

  // Registered read data; holds when no read load occurs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_out_q <= INIT_VALUE;
    end else if (rvalid_d) begin
      data_out_q <= mem[addr_q];
    end
  end

  assign data_out = data_out_q;
`endif

  // Control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      selected_q <= 1'b0;
      addr_q     <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      selected_q <= selected_d;
      addr_q     <= addr_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Array write uses the address latched before this edge; suppressed in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && selected_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_c[i]) begin
          mem[addr_q][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  assign data_oe = ~oe_n & rvalid_q;

endmodule

// File: tb/tb_ssram_responder.sv
// Scoreboard bench for ssram_responder (default pipelined build).
module tb_ssram_responder;

  localparam int unsigned AW   = 10;
  localparam logic [31:0] INIT = 32'hCAFE_F00D;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [26:0] address_in;
  logic        adsp_n, adsc_n, adv_n, gw_n, we_n, oe_n, ce_n;
  logic [3:0]  be_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_oe;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  bit use_adsc = 1'b0;

  ssram_responder #(.ADDR_WIDTH(AW), .INIT_VALUE(INIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .address_in(address_in),
    .adsp_n(adsp_n), .adsc_n(adsc_n), .adv_n(adv_n), .gw_n(gw_n),
    .we_n(we_n), .be_n(be_n), .oe_n(oe_n), .ce_n(ce_n),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every driven bus cycle must match the next scoreboard entry.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && data_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drive: data_oe=1 data_out=%h with nothing expected", data_out);
      end else begin
        check("read_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    adsp_n = 1'b1; adsc_n = 1'b1; adv_n = 1'b1; gw_n = 1'b1; we_n = 1'b1;
    be_n = 4'hF; oe_n = 1'b1; ce_n = 1'b1; data_in = 32'h0;
  endtask

  task automatic strobe(input logic [26:0] a);
    address_in = a;
    ce_n = 1'b0;
    if (use_adsc) adsc_n = 1'b0; else adsp_n = 1'b0;
  endtask

  task automatic deselect;
    adsp_n = 1'b0;
    ce_n   = 1'b1;
  endtask

  task automatic write_word(input logic [26:0] a, input logic [31:0] d,
                            input logic [3:0] be, input bit global);
    idle(); strobe(a); tick();
    idle(); data_in = d; be_n = be;
    if (global) gw_n = 1'b0; else we_n = 1'b0;
    tick();
    idle(); deselect(); tick();
    idle(); tick();
  endtask

  task automatic read_word(input logic [26:0] a, input logic [31:0] exp);
    idle(); strobe(a); tick();
    idle(); tick();
    idle(); oe_n = 1'b0; exp_q.push_back(exp); deselect(); tick();
    idle(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    address_in = '0;
    rst_i = 1'b1;
    tick(); tick();
    check("reset_data_out", data_out, INIT);
    check("reset_data_oe", 32'(data_oe), 32'h0);
    rst_i = 1'b0;
    tick();

    // Full-word write then read.
    write_word(27'h005, 32'hDEAD_BEEF, 4'h0, 1'b0);
    read_word(27'h005, 32'hDEAD_BEEF);

    // Byte lanes, then global write over be_n=F.
    write_word(27'h010, 32'h1122_3344, 4'h0, 1'b0);
    write_word(27'h010, 32'hAABB_CCDD, 4'b1010, 1'b0);
    read_word(27'h010, 32'h11BB_33DD);
    write_word(27'h010, 32'h0000_0000, 4'hF, 1'b1);
    read_word(27'h010, 32'h0000_0000);

    // Burst wrap from 0x00E.
    write_word(27'h00C, 32'hC0C0_000C, 4'h0, 1'b0);
    write_word(27'h00D, 32'hD0D0_000D, 4'h0, 1'b0);
    write_word(27'h00E, 32'hE0E0_000E, 4'h0, 1'b0);
    write_word(27'h00F, 32'hF0F0_000F, 4'h0, 1'b0);
    idle(); strobe(27'h00E); tick();
    idle(); adv_n = 1'b0; tick();
    oe_n = 1'b0; exp_q.push_back(32'hE0E0_000E); tick();
    exp_q.push_back(32'hF0F0_000F); tick();
    adv_n = 1'b1; exp_q.push_back(32'hC0C0_000C); tick();
    exp_q.push_back(32'hD0D0_000D); deselect(); tick();
    idle(); tick();

    // Deselected chip ignores a following write.
    write_word(27'h020, 32'h55AA_55AA, 4'h0, 1'b0);
    idle(); deselect(); address_in = 27'h020; tick();
    idle(); we_n = 1'b0; be_n = 4'h0; data_in = 32'hFFFF_FFFF; tick();
    tick();
    idle(); tick();
    read_word(27'h020, 32'h55AA_55AA);

    // Aliasing of address bits above ADDR_WIDTH, latched via ADSC.
    use_adsc = 1'b1;
    write_word(27'((1 << AW) | 3), 32'h1357_9BDF, 4'h0, 1'b0);
    read_word(27'h003, 32'h1357_9BDF);
    use_adsc = 1'b0;
    read_word(27'h7403, 32'h1357_9BDF);

    // Reset mid-read with a write pending.
    idle(); strobe(27'h005); tick();
    idle(); tick();
    oe_n = 1'b0; we_n = 1'b0; be_n = 4'h0; data_in = 32'h1234_5678;
    #1;
    check("pre_reset_oe", 32'(data_oe), 32'h1);
    check("pre_reset_data", data_out, 32'hDEAD_BEEF);
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_data", data_out, INIT);
    check("async_reset_oe", 32'(data_oe), 32'h0);
    tick();
    rst_i = 1'b0; oe_n = 1'b1;
    tick(); tick();
    check("post_reset_hold", data_out, INIT);
    idle(); tick();
    read_word(27'h005, 32'hDEAD_BEEF);

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
